// File: rtl/cache_ctrl_pkg.sv
// rtl/cache_ctrl_pkg.sv - shared state encoding and default parameters for the refill controller
package cache_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 128;
  localparam int DEF_TIMEOUT    = 256;
  localparam int STAT_WIDTH     = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_CHECK,
    ST_WR_CACHE,
    ST_MEM_REQ,
    ST_MEM_WAIT,
    ST_FILL,
    ST_RESP
  } cache_ctrl_state_t;

endpackage

// File: rtl/cache_stat_ctr.sv
// rtl/cache_stat_ctr.sv - saturating statistics counter with async active-low clear
module cache_stat_ctr
  import cache_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  i_inc,
  output logic [STAT_WIDTH-1:0] o_count
);

  logic [STAT_WIDTH-1:0] r_count;

  // count up on each increment request, holding at all-ones instead of wrapping
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - direct-mapped cache port owner with write-through refill and memory timeout
module cache_refill_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_hit,
  output logic                  rsp_err,
  output logic                  c_read_en,
  output logic                  c_write_en,
  output logic [ADDR_WIDTH-1:0] c_addr,
  output logic [DATA_WIDTH-1:0] c_write_data,
  input  logic [DATA_WIDTH-1:0] c_read_data,
  input  logic                  c_hit,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_write,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic [STAT_WIDTH-1:0] hit_cnt,
  output logic [STAT_WIDTH-1:0] miss_cnt
);

  // a zero TIMEOUT still needs a legal one-bit counter; the compare is disabled in that case
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  cache_ctrl_state_t r_state;
  cache_ctrl_state_t w_next;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_hit;
  logic                  r_err;
  logic [TW-1:0]         r_tmo;

  logic w_tmo_exp;
  logic w_hit_inc;
  logic w_miss_inc;

  // the final MEM_WAIT cycle is the TIMEOUT-th one; a response in that same cycle still wins
  assign w_tmo_exp = (TIMEOUT != 0) && (r_tmo == TMO_LAST);

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // request latch, result capture and memory wait counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_data  <= '0;
      r_hit   <= 1'b0;
      r_err   <= 1'b0;
      r_tmo   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_addr  <= req_addr;
            r_write <= req_write;
            r_wdata <= req_wdata;
            r_data  <= '0;
            r_hit   <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        ST_CHECK: begin
          if (c_hit) begin
            r_data <= c_read_data;
            r_hit  <= 1'b1;
          end
        end
        ST_MEM_REQ: begin
          r_tmo <= '0;
        end
        ST_MEM_WAIT: begin
          r_tmo <= r_tmo + 1'b1;
          if (mem_rsp_valid) begin
            r_data <= mem_rsp_data;
          end else if (w_tmo_exp) begin
            r_err <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // next-state and output decode from current state and latched request
  always_comb begin
    w_next        = r_state;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    rsp_data      = '0;
    rsp_hit       = 1'b0;
    rsp_err       = 1'b0;
    c_read_en     = 1'b0;
    c_write_en    = 1'b0;
    c_addr        = '0;
    c_write_data  = '0;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    w_hit_inc     = 1'b0;
    w_miss_inc    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_next = req_write ? ST_WR_CACHE : ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        c_read_en = 1'b1;
        c_addr    = r_addr;
        w_next    = ST_CHECK;
      end
      ST_CHECK: begin
        w_hit_inc  = c_hit;
        w_miss_inc = ~c_hit;
        w_next     = c_hit ? ST_RESP : ST_MEM_REQ;
      end
      ST_WR_CACHE: begin
        c_write_en   = 1'b1;
        c_addr       = r_addr;
        c_write_data = r_wdata;
        w_next       = ST_MEM_REQ;
      end
      ST_MEM_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_write = r_write;
        mem_req_addr  = r_addr;
        mem_req_wdata = r_write ? r_wdata : '0;
        if (mem_req_ready) begin
          w_next = r_write ? ST_RESP : ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_rsp_valid) begin
          w_next = ST_FILL;
        end else if (w_tmo_exp) begin
          w_next = ST_RESP;
        end
      end
      ST_FILL: begin
        c_write_en   = 1'b1;
        c_addr       = r_addr;
        c_write_data = r_data;
        w_next       = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_data  = r_data;
        rsp_hit   = r_hit;
        rsp_err   = r_err;
        w_next    = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  cache_stat_ctr u_hit_ctr (
    .clk     (clk),
    .clr_n   (reset_n),
    .i_inc   (w_hit_inc),
    .o_count (hit_cnt)
  );

  cache_stat_ctr u_miss_ctr (
    .clk     (clk),
    .clr_n   (reset_n),
    .i_inc   (w_miss_inc),
    .o_count (miss_cnt)
  );

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - self-checking bench for cache_refill_ctrl
module tb_cache_refill_ctrl;

  localparam int AW = 32;
  localparam int DW = 128;
  localparam int MEM_L = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_hit;
  logic          rsp_err;
  logic          c_read_en;
  logic          c_write_en;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_write_data;
  logic [DW-1:0] c_read_data = '0;
  logic          c_hit = 1'b0;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic          mem_req_write;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_data = '0;
  logic [31:0]   hit_cnt;
  logic [31:0]   miss_cnt;

  logic          mem_ready = 1'b1;
  logic          mem_silent = 1'b0;
  logic          late_pulse = 1'b0;
  int            mem_cnt = 0;

  logic [DW-1:0] cache_model [logic [AW-1:0]];
  logic [DW-1:0] mem_model   [logic [AW-1:0]];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          hit;
    logic          err;
  } rsp_exp_t;
  rsp_exp_t sb_q[$];

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_data;
    logic          exp_hit;
    logic          exp_err;
    int            exp_lat;
    int            exp_fills;
  } vec_t;
  vec_t vecs [6];

  cache_refill_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_hit       (rsp_hit),
    .rsp_err       (rsp_err),
    .c_read_en     (c_read_en),
    .c_write_en    (c_write_en),
    .c_addr        (c_addr),
    .c_write_data  (c_write_data),
    .c_read_data   (c_read_data),
    .c_hit         (c_hit),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_write (mem_req_write),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt)
  );

  always #5 clk = ~clk;

  assign mem_req_ready = mem_ready;
  assign mem_rsp_valid = (mem_cnt == 1) || late_pulse;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // cache model: registered hit/data one cycle after the read strobe
  always @(posedge clk) begin
    if (c_write_en) cache_model[c_addr] = c_write_data;
    if (c_read_en) begin
      c_hit       <= cache_model.exists(c_addr);
      c_read_data <= cache_model.exists(c_addr) ? cache_model[c_addr] : '0;
    end else begin
      c_hit       <= 1'b0;
      c_read_data <= '0;
    end
  end

  // memory model: reads answer MEM_L cycles after MEM_WAIT entry unless silenced
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_cnt <= 0;
    end else if (mem_req_valid && mem_req_ready) begin
      if (mem_req_write) begin
        mem_model[mem_req_addr] = mem_req_wdata;
      end else if (!mem_silent) begin
        mem_cnt      <= MEM_L + 1;
        mem_rsp_data <= mem_model.exists(mem_req_addr) ? mem_model[mem_req_addr] : '0;
      end
    end else if (mem_cnt != 0) begin
      mem_cnt <= mem_cnt - 1;
    end
  end

  // response scoreboard and strobe exclusivity monitor
  always @(negedge clk) begin
    chk("strobe_excl", {127'd0, c_read_en & c_write_en}, '0);
    if (rsp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rsp", 1, 0);
      end else begin
        rsp_exp_t e;
        e = sb_q.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_hit", {127'd0, rsp_hit}, {127'd0, e.hit});
        chk("rsp_err", {127'd0, rsp_err}, {127'd0, e.err});
      end
    end
  end

  task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [DW-1:0] ed, input logic eh, input logic ee,
                         input int elat, input int efills, input int hold);
    int  fills;
    bit  done;
    fills = 0;
    done  = 0;
    @(negedge clk);
    chk("req_ready_idle", {127'd0, req_ready}, 1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    sb_q.push_back('{ed, eh, ee});
    if (hold > 0) mem_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    for (int k = 1; k <= 60 && !done; k++) begin
      @(negedge clk);
      if (c_write_en) fills++;
      if (wr && k == 1) begin
        chk("wr_c_write_en", {127'd0, c_write_en}, 1);
        chk("wr_c_addr", {96'd0, c_addr}, {96'd0, addr});
        chk("wr_c_data", c_write_data, wdata);
      end
      if (wr && k >= 2 && k <= 2 + hold) begin
        chk("wr_mem_valid", {127'd0, mem_req_valid}, 1);
        chk("wr_mem_write", {127'd0, mem_req_write}, 1);
        chk("wr_mem_addr", {96'd0, mem_req_addr}, {96'd0, addr});
        chk("wr_mem_wdata", mem_req_wdata, wdata);
        chk("busy_req_ready", {127'd0, req_ready}, 0);
      end
      if (hold > 0 && k == hold + 2) mem_ready = 1'b1;
      if (rsp_valid) begin
        chk("latency", k, elat);
        done = 1;
      end
    end
    if (!done) chk("rsp_wait_bound", 0, 1);
    chk("fill_strobes", fills, efills);
    mem_ready = 1'b1;
  endtask

  initial begin
    bit seen;
    vecs[0] = '{1'b0, 32'h40, '0,        128'hDEAD, 1'b0, 1'b0, 9, 1};
    vecs[1] = '{1'b0, 32'h40, '0,        128'hDEAD, 1'b1, 1'b0, 3, 0};
    vecs[2] = '{1'b1, 32'h80, 128'h1234, '0,        1'b0, 1'b0, 3, 1};
    vecs[3] = '{1'b0, 32'h80, '0,        128'h1234, 1'b1, 1'b0, 3, 0};
    vecs[4] = '{1'b0, 32'hC0, '0,        128'h5555, 1'b0, 1'b0, 9, 1};
    vecs[5] = '{1'b0, 32'hC0, '0,        128'h5555, 1'b1, 1'b0, 3, 0};
    mem_model[32'h40] = 128'hDEAD;
    mem_model[32'hC0] = 128'h5555;

    #1;
    chk("rst_req_ready", {127'd0, req_ready}, 1);
    chk("rst_rsp_valid", {127'd0, rsp_valid}, 0);
    chk("rst_mem_req_valid", {127'd0, mem_req_valid}, 0);
    chk("rst_c_strobes", {126'd0, c_read_en, c_write_en}, 0);
    chk("rst_hit_cnt", {96'd0, hit_cnt}, 0);
    chk("rst_miss_cnt", {96'd0, miss_cnt}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i])
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_data,
              vecs[i].exp_hit, vecs[i].exp_err, vecs[i].exp_lat, vecs[i].exp_fills, 0);
    chk("hit_cnt_table", {96'd0, hit_cnt}, 3);
    chk("miss_cnt_table", {96'd0, miss_cnt}, 2);

    run_txn(1'b1, 32'hA0, 128'h77, '0, 1'b0, 1'b0, 8, 1, 5);

    mem_silent = 1'b1;
    run_txn(1'b0, 32'h100, '0, '0, 1'b0, 1'b1, 8, 0, 0);
    mem_silent = 1'b0;
    chk("miss_cnt_timeout", {96'd0, miss_cnt}, 3);
    @(negedge clk);
    late_pulse = 1'b1;
    @(negedge clk);
    late_pulse = 1'b0;
    chk("late_rsp_idle", {127'd0, req_ready}, 1);
    chk("late_rsp_no_fill", {127'd0, c_write_en}, 0);
    run_txn(1'b0, 32'h40, '0, 128'hDEAD, 1'b1, 1'b0, 3, 0, 0);
    chk("hit_cnt_after_late", {96'd0, hit_cnt}, 4);

    mem_silent = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h200;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = '0;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (mem_req_valid) seen = 1;
    end
    if (!seen) chk("mem_req_wait_bound", 0, 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", {127'd0, req_ready}, 1);
    chk("mid_rst_mem_req_valid", {127'd0, mem_req_valid}, 0);
    chk("mid_rst_c_strobes", {126'd0, c_read_en, c_write_en}, 0);
    chk("mid_rst_rsp_valid", {127'd0, rsp_valid}, 0);
    chk("mid_rst_hit_cnt", {96'd0, hit_cnt}, 0);
    chk("mid_rst_miss_cnt", {96'd0, miss_cnt}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    mem_silent = 1'b0;
    run_txn(1'b0, 32'h40, '0, 128'hDEAD, 1'b1, 1'b0, 3, 0, 0);
    chk("post_rst_hit_cnt", {96'd0, hit_cnt}, 1);
    chk("post_rst_miss_cnt", {96'd0, miss_cnt}, 0);

    @(negedge clk);
    force dut.u_hit_ctr.r_count = 32'hFFFF_FFFE;
    #1;
    release dut.u_hit_ctr.r_count;
    for (int n = 0; n < 3; n++) begin
      run_txn(1'b0, 32'h40, '0, 128'hDEAD, 1'b1, 1'b0, 3, 0, 0);
      chk("hit_cnt_saturate", {96'd0, hit_cnt}, 128'hFFFF_FFFF);
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
